// File: rtl/elevator_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler_if
// Description : Request, sensor and car-control bundle of the elevator
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_scheduler_if #(
    parameter int FLOORS = 10
);
    logic              req_valid;
    logic [3:0]        req_floor;
    logic              req_auth;
    logic              floor_tick;
    logic              motor_up;
    logic              motor_down;
    logic              door_open;
    logic [3:0]        cur_floor;
    logic [FLOORS-1:0] pending;
    logic              dir_up;
    logic              req_reject;

    modport master (
        output req_valid, req_floor, req_auth, floor_tick,
        input  motor_up, motor_down, door_open, cur_floor, pending, dir_up, req_reject
    );

    modport slave (
        input  req_valid, req_floor, req_auth, floor_tick,
        output motor_up, motor_down, door_open, cur_floor, pending, dir_up, req_reject
    );
endinterface
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : SCAN floor scheduler sequencing motor and door of the car.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
    parameter int FLOORS      = 10,
    parameter int DOOR_CYCLES = 8
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    elevator_scheduler_if.slave    bus
);
    localparam int              CW          = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0]   c_door_load = CW'(DOOR_CYCLES);
    localparam logic [CW-1:0]   c_one       = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [3:0]        r_cur_floor, w_floor_nxt;
    logic [FLOORS-1:0] r_pending,   w_pending_nxt;
    logic              r_dir_up,    w_dir_nxt;
    logic [CW-1:0]     r_door_cnt,  w_cnt_nxt;
    logic              r_req_reject;

    logic              w_req_ok;
    logic              w_req_bad;
    logic              w_absorb;
    logic              w_clear;
    logic [3:0]        w_clear_idx;
    logic [3:0]        w_new_up;
    logic [3:0]        w_new_dn;

    function automatic logic f_above(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (p[i] && (i > int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic f_below(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (p[i] && (i < int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic f_at(input logic [FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i == int'(f)) r = p[i];
        return r;
    endfunction

    function automatic logic [FLOORS-1:0] f_mask(input logic [3:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++)
            if (i == int'(f)) m[i] = 1'b1;
        return m;
    endfunction

    assign w_req_ok  = bus.req_valid && bus.req_auth && (int'(bus.req_floor) < FLOORS);
    assign w_req_bad = bus.req_valid && !w_req_ok;

    // Ticks past either end of the shaft saturate rather than wrap.
    assign w_new_up = (int'(r_cur_floor) >= FLOORS - 1) ? r_cur_floor : r_cur_floor + 4'd1;
    assign w_new_dn = (r_cur_floor == 4'd0) ? r_cur_floor : r_cur_floor - 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_cur_floor;
        w_dir_nxt   = r_dir_up;
        w_cnt_nxt   = r_door_cnt;
        w_absorb    = 1'b0;
        w_clear     = 1'b0;
        w_clear_idx = r_cur_floor;

        case (r_state)
            S_IDLE: begin
                w_absorb = w_req_ok && (bus.req_floor == r_cur_floor);
                if (f_at(r_pending, r_cur_floor)) begin
                    w_state_nxt = S_DOOR;
                    w_clear     = 1'b1;
                    w_cnt_nxt   = c_door_load;
                end else if (r_dir_up) begin
                    if (f_above(r_pending, r_cur_floor)) begin
                        w_state_nxt = S_MOVE_UP;
                    end else if (f_below(r_pending, r_cur_floor)) begin
                        w_state_nxt = S_MOVE_DOWN;
                        w_dir_nxt   = 1'b0;
                    end
                end else begin
                    if (f_below(r_pending, r_cur_floor)) begin
                        w_state_nxt = S_MOVE_DOWN;
                    end else if (f_above(r_pending, r_cur_floor)) begin
                        w_state_nxt = S_MOVE_UP;
                        w_dir_nxt   = 1'b1;
                    end
                end
            end
            S_MOVE_UP: begin
                if (bus.floor_tick) begin
                    w_floor_nxt = w_new_up;
                    if (f_at(r_pending, w_new_up)) begin
                        w_state_nxt = S_DOOR;
                        w_clear     = 1'b1;
                        w_clear_idx = w_new_up;
                        w_cnt_nxt   = c_door_load;
                    end else if (!f_above(r_pending, w_new_up)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (bus.floor_tick) begin
                    w_floor_nxt = w_new_dn;
                    if (f_at(r_pending, w_new_dn)) begin
                        w_state_nxt = S_DOOR;
                        w_clear     = 1'b1;
                        w_clear_idx = w_new_dn;
                        w_cnt_nxt   = c_door_load;
                    end else if (!f_below(r_pending, w_new_dn)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // A call from the landing the car is standing at keeps the door open.
                if (w_req_ok && (bus.req_floor == r_cur_floor)) begin
                    w_absorb  = 1'b1;
                    w_cnt_nxt = c_door_load;
                end else if (r_door_cnt <= c_one) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_door_cnt - c_one;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear is applied after set so an arrival swallows a same-cycle call for that floor.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_req_ok && !w_absorb) w_pending_nxt = w_pending_nxt | f_mask(bus.req_floor);
        if (w_clear)               w_pending_nxt = w_pending_nxt & ~f_mask(w_clear_idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_cur_floor  <= 4'd0;
            r_pending    <= '0;
            r_dir_up     <= 1'b1;
            r_door_cnt   <= '0;
            r_req_reject <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_floor  <= w_floor_nxt;
            r_pending    <= w_pending_nxt;
            r_dir_up     <= w_dir_nxt;
            r_door_cnt   <= w_cnt_nxt;
            r_req_reject <= w_req_bad;
        end
    end

    assign bus.motor_up   = (r_state == S_MOVE_UP);
    assign bus.motor_down = (r_state == S_MOVE_DOWN);
    assign bus.door_open  = (r_state == S_DOOR);
    assign bus.cur_floor  = r_cur_floor;
    assign bus.pending    = r_pending;
    assign bus.dir_up     = r_dir_up;
    assign bus.req_reject = r_req_reject;
endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Directed self-checking bench for elevator_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;
    localparam int FLOORS = 10;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    int   sb_q[$];
    logic r_prev_door;
    int   cnt;
    int   guard;

    elevator_scheduler_if #(.FLOORS(FLOORS)) bus ();

    elevator_scheduler #(.FLOORS(FLOORS), .DOOR_CYCLES(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send_req(input logic [3:0] floor, input logic auth);
        bus.req_valid = 1'b1;
        bus.req_floor = floor;
        bus.req_auth  = auth;
        step();
        bus.req_valid = 1'b0;
        bus.req_auth  = 1'b0;
    endtask

    task automatic do_tick();
        bus.floor_tick = 1'b1;
        step();
        bus.floor_tick = 1'b0;
    endtask

    task automatic wait_motor();
        int g;
        g = 0;
        while (!(bus.motor_up || bus.motor_down) && g < 10) begin
            step();
            g++;
        end
        check("motor_on", 32'(bus.motor_up | bus.motor_down), 32'd1);
    endtask

    task automatic wait_door_close();
        int g;
        g = 0;
        while (bus.door_open && g < 40) begin
            step();
            g++;
        end
        check("door_closed", 32'(bus.door_open), 32'd0);
    endtask

    // Scoreboard: every door opening must match the next expected stop.
    always @(negedge CLK) begin
        if (bus.door_open && !r_prev_door) begin
            check("stop_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("stop_floor", 32'(bus.cur_floor), 32'(sb_q.pop_front()));
        end
        r_prev_door = bus.door_open;
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        r_prev_door    = 1'b0;
        RST            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_floor  = 4'd0;
        bus.req_auth   = 1'b0;
        bus.floor_tick = 1'b0;
        repeat (2) step();

        check("rst_motor_up",   32'(bus.motor_up),   32'd0);
        check("rst_motor_down", 32'(bus.motor_down), 32'd0);
        check("rst_door",       32'(bus.door_open),  32'd0);
        check("rst_floor",      32'(bus.cur_floor),  32'd0);
        check("rst_pending",    32'(bus.pending),    32'd0);
        check("rst_dir",        32'(bus.dir_up),     32'd1);
        check("rst_reject",     32'(bus.req_reject), 32'd0);
        RST = 1'b0;
        step();

        // Single request up to floor 3.
        sb_q.push_back(3);
        send_req(4'd3, 1'b1);
        check("t1_pending", 32'(bus.pending), 32'h008);
        check("t1_motor_early", 32'(bus.motor_up), 32'd0);
        step();
        check("t1_motor_up", 32'(bus.motor_up), 32'd1);
        check("t1_dir", 32'(bus.dir_up), 32'd1);
        repeat (3) do_tick();
        check("t1_door", 32'(bus.door_open), 32'd1);
        check("t1_floor", 32'(bus.cur_floor), 32'd3);
        check("t1_motor_off", 32'(bus.motor_up), 32'd0);
        cnt = 0;
        guard = 0;
        while (bus.door_open && guard < 40) begin
            cnt++;
            step();
            guard++;
        end
        check("t1_dwell", 32'(cnt), 32'd8);
        check("t1_pending_end", 32'(bus.pending), 32'd0);
        check("t1_idle_motor", 32'(bus.motor_up | bus.motor_down), 32'd0);

        // Move to floor 5, then SCAN: 7 before 2.
        sb_q.push_back(5);
        send_req(4'd5, 1'b1);
        wait_motor();
        repeat (2) do_tick();
        wait_door_close();
        check("t2_floor5", 32'(bus.cur_floor), 32'd5);
        sb_q.push_back(7);
        sb_q.push_back(2);
        send_req(4'd7, 1'b1);
        send_req(4'd2, 1'b1);
        check("t2_pending", 32'(bus.pending), 32'h084);
        check("t2_motor_up", 32'(bus.motor_up), 32'd1);
        repeat (2) do_tick();
        check("t2_at7", 32'(bus.cur_floor), 32'd7);
        wait_door_close();
        step();
        check("t2_motor_down", 32'(bus.motor_down), 32'd1);
        check("t2_dir_down", 32'(bus.dir_up), 32'd0);
        repeat (3) do_tick();
        check("t2_descent_dir", 32'(bus.dir_up), 32'd0);
        check("t2_descent_floor", 32'(bus.cur_floor), 32'd4);
        repeat (2) do_tick();
        check("t2_at2", 32'(bus.cur_floor), 32'd2);
        wait_door_close();
        check("t2_pending_end", 32'(bus.pending), 32'd0);

        // Rejects: unauthorised, then out-of-range floor.
        send_req(4'd4, 1'b0);
        check("t3_reject_auth", 32'(bus.req_reject), 32'd1);
        check("t3_pending_a", 32'(bus.pending), 32'd0);
        step();
        check("t3_reject_clear_a", 32'(bus.req_reject), 32'd0);
        send_req(4'd11, 1'b1);
        check("t3_reject_range", 32'(bus.req_reject), 32'd1);
        check("t3_pending_b", 32'(bus.pending), 32'd0);
        step();
        check("t3_reject_clear_b", 32'(bus.req_reject), 32'd0);
        check("t3_motor_idle", 32'(bus.motor_up | bus.motor_down), 32'd0);
        do_tick();
        check("t3_tick_ignored", 32'(bus.cur_floor), 32'd2);

        // Same-floor call on the fourth open cycle extends the dwell to 12.
        sb_q.push_back(3);
        send_req(4'd3, 1'b1);
        wait_motor();
        do_tick();
        check("t4_door", 32'(bus.door_open), 32'd1);
        cnt = 0;
        repeat (3) begin
            if (bus.door_open) cnt++;
            step();
        end
        if (bus.door_open) cnt++;
        bus.req_valid = 1'b1;
        bus.req_floor = 4'd3;
        bus.req_auth  = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.req_auth  = 1'b0;
        check("t4_no_pending", 32'(bus.pending), 32'd0);
        guard = 0;
        while (bus.door_open && guard < 40) begin
            cnt++;
            step();
            guard++;
        end
        check("t4_dwell", 32'(cnt), 32'd12);

        // Arrival at 6 coinciding with a new call for 6.
        sb_q.push_back(6);
        send_req(4'd6, 1'b1);
        wait_motor();
        repeat (2) do_tick();
        bus.floor_tick = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_floor  = 4'd6;
        bus.req_auth   = 1'b1;
        step();
        bus.floor_tick = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_auth   = 1'b0;
        check("t5_door", 32'(bus.door_open), 32'd1);
        check("t5_floor", 32'(bus.cur_floor), 32'd6);
        check("t5_pending", 32'(bus.pending), 32'd0);
        wait_door_close();
        repeat (2) step();
        check("t5_single_stop", 32'(bus.door_open | bus.motor_up | bus.motor_down), 32'd0);

        // Reset while descending with floors 0 and 1 pending.
        send_req(4'd1, 1'b1);
        send_req(4'd0, 1'b1);
        wait_motor();
        check("t6_motor_down", 32'(bus.motor_down), 32'd1);
        check("t6_pending", 32'(bus.pending), 32'h003);
        do_tick();
        RST = 1'b1;
        #1;
        check("t6_motor", 32'(bus.motor_up | bus.motor_down), 32'd0);
        check("t6_door", 32'(bus.door_open), 32'd0);
        check("t6_floor", 32'(bus.cur_floor), 32'd0);
        check("t6_pending_lost", 32'(bus.pending), 32'd0);
        check("t6_dir", 32'(bus.dir_up), 32'd1);
        step();
        RST = 1'b0;
        step();
        repeat (2) do_tick();
        check("t6_tick_ignored", 32'(bus.cur_floor), 32'd0);
        check("t6_still_idle", 32'(bus.motor_up | bus.motor_down | bus.door_open), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
